// File: rtl/pipeline_ctrl_pkg.sv
// =============================================================================
// pipeline_ctrl_pkg : shared types and constants for the pipeline controller  (rev 1.0)
// =============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         DEF_CNT_W   = 32;
  localparam int         DEF_TIMEOUT = 1024;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// =============================================================================
// hazard_detect : combinational load-use detector between ID and EX  (rev 1.0)
// =============================================================================
`default_nettype none

module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       IDEX_MemRead_i,
  input  logic [4:0] IDEX_RDaddr_i,
  input  logic [4:0] IFID_RS1addr_i,
  input  logic [4:0] IFID_RS2addr_i,
  input  logic       IFID_UsesRS1_i,
  input  logic       IFID_UsesRS2_i,
  output logic       lu_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign w_rs1_hit = IFID_UsesRS1_i && (IFID_RS1addr_i == IDEX_RDaddr_i);
  assign w_rs2_hit = IFID_UsesRS2_i && (IFID_RS2addr_i == IDEX_RDaddr_i);
  assign lu_o      = IDEX_MemRead_i && (IDEX_RDaddr_i != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// =============================================================================
// pipeline_ctrl : stall/flush sequencer with perf counters and miss watchdog  (rev 1.0)
// =============================================================================
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  input  logic [4:0]       IFID_RS1addr_i,
  input  logic [4:0]       IFID_RS2addr_i,
  input  logic             IFID_UsesRS1_i,
  input  logic             IFID_UsesRS2_i,
  input  logic             BranchTaken_i,
  input  logic             DcacheReq_i,
  input  logic             DcacheAck_i,
  output logic             PCWrite_o,
  output logic             IFIDStall_o,
  output logic             IFIDFlush_o,
  output logic             IDEXStall_o,
  output logic             IDEXBubble_o,
  output logic             EXMEMStall_o,
  output logic             MEMWBStall_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_o
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_e            state_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  bubble_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              err_q;

  logic w_lu;
  logic w_miss;
  logic w_freeze;

  hazard_detect u_hazard_detect (
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RDaddr_i  (IDEX_RDaddr_i),
    .IFID_RS1addr_i (IFID_RS1addr_i),
    .IFID_RS2addr_i (IFID_RS2addr_i),
    .IFID_UsesRS1_i (IFID_UsesRS1_i),
    .IFID_UsesRS2_i (IFID_UsesRS2_i),
    .lu_o           (w_lu)
  );

  assign w_miss   = DcacheReq_i && !DcacheAck_i;
  // Once waiting, only the ack matters: the request stays asserted by a frozen MEM stage
  assign w_freeze = ((state_q == RUN) && w_miss) || ((state_q == MEMWAIT) && !DcacheAck_i);

  always_comb begin
    PCWrite_o    = 1'b1;
    IFIDStall_o  = 1'b0;
    IFIDFlush_o  = 1'b0;
    IDEXStall_o  = 1'b0;
    IDEXBubble_o = 1'b0;
    EXMEMStall_o = 1'b0;
    MEMWBStall_o = 1'b0;
    if (rst_i) begin
      PCWrite_o    = 1'b0;
      IFIDFlush_o  = 1'b1;
      IDEXBubble_o = 1'b1;
    end else if (w_freeze) begin
      PCWrite_o    = 1'b0;
      IFIDStall_o  = 1'b1;
      IDEXStall_o  = 1'b1;
      EXMEMStall_o = 1'b1;
      MEMWBStall_o = 1'b1;
    end else if (w_lu) begin
      // Branch in ID waits for the forwarded operand, so no flush this cycle
      PCWrite_o    = 1'b0;
      IFIDStall_o  = 1'b1;
      IDEXBubble_o = 1'b1;
    end else if (BranchTaken_i) begin
      IFIDFlush_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      wait_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (w_miss) begin
            state_q <= MEMWAIT;
            wait_q  <= '0;
          end
        end
        MEMWAIT: begin
          if (DcacheAck_i) begin
            state_q <= RUN;
          end else if (wait_q != WAIT_MAX) begin
            wait_q <= wait_q + WAIT_ONE;
            if (wait_q == WAIT_LAST) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= RUN;
      endcase
      if (w_freeze && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (IDEXBubble_o && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
      end
      if (IFIDFlush_o && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// =============================================================================
// tb_pipeline_ctrl : directed scoreboard bench for pipeline_ctrl  (rev 1.0)
// =============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  // Control vector order: PCWrite, IFIDStall, IFIDFlush, IDEXStall, IDEXBubble, EXMEMStall, MEMWBStall
  localparam logic [6:0] C_RUN = 7'b1000000;
  localparam logic [6:0] C_FRZ = 7'b0101011;
  localparam logic [6:0] C_LU  = 7'b0100100;
  localparam logic [6:0] C_FL  = 7'b1010000;
  localparam logic [6:0] C_RST = 7'b0010100;

  typedef struct {
    int          id;
    logic [6:0]  ctrl;
    logic [31:0] st;
    logic [31:0] bu;
    logic [31:0] fl;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        memrd;
  logic [4:0]  rd, rs1, rs2;
  logic        use1, use2, br, req, ack;
  logic        pcw, ifst, iffl, idst, idbu, exst, mwst, err;
  logic [31:0] stc, buc, flc;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32), .TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRead_i (memrd),
    .IDEX_RDaddr_i  (rd),
    .IFID_RS1addr_i (rs1),
    .IFID_RS2addr_i (rs2),
    .IFID_UsesRS1_i (use1),
    .IFID_UsesRS2_i (use2),
    .BranchTaken_i  (br),
    .DcacheReq_i    (req),
    .DcacheAck_i    (ack),
    .PCWrite_o      (pcw),
    .IFIDStall_o    (ifst),
    .IFIDFlush_o    (iffl),
    .IDEXStall_o    (idst),
    .IDEXBubble_o   (idbu),
    .EXMEMStall_o   (exst),
    .MEMWBStall_o   (mwst),
    .stall_cnt_o    (stc),
    .bubble_cnt_o   (buc),
    .flush_cnt_o    (flc),
    .err_o          (err)
  );

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("ctrl",   e.id, {25'd0, pcw, ifst, iffl, idst, idbu, exst, mwst}, {25'd0, e.ctrl});
      cmp("stall",  e.id, stc, e.st);
      cmp("bubble", e.id, buc, e.bu);
      cmp("flush",  e.id, flc, e.fl);
      cmp("err",    e.id, {31'd0, err}, {31'd0, e.err});
    end
  end

  task automatic set_in(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic u1, input logic u2, input logic b,
                        input logic rq, input logic ak);
    rst = r; memrd = m; rd = d; rs1 = s1; rs2 = s2;
    use1 = u1; use2 = u2; br = b; req = rq; ack = ak;
  endtask

  task automatic step(input logic [6:0] c, input int st, input int bu, input int fl, input logic er);
    exp_t x;
    x.id = step_id; x.ctrl = c; x.st = st; x.bu = bu; x.fl = fl; x.err = er;
    q.push_back(x);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    //     rst mrd rd  rs1 rs2 u1 u2 br rq ak
    step(C_RST, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step(C_RUN, 0, 0, 0, 0);
    // load-use on rs1, then release
    set_in(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);  step(C_LU,  0, 0, 0, 0);
    set_in(0, 0, 5, 5, 0, 1, 0, 0, 0, 0);  step(C_RUN, 0, 1, 0, 0);
    set_in(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);  step(C_RUN, 0, 1, 0, 0);
    set_in(0, 1, 7, 3, 7, 1, 1, 0, 0, 0);  step(C_LU,  0, 1, 0, 0);
    set_in(0, 1, 7, 3, 7, 1, 0, 0, 0, 0);  step(C_RUN, 0, 2, 0, 0);
    // taken branch, then branch together with load-use
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  step(C_FL,  0, 2, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step(C_RUN, 0, 2, 1, 0);
    set_in(0, 1, 9, 9, 0, 1, 0, 1, 0, 0);  step(C_LU,  0, 2, 1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step(C_RUN, 0, 3, 1, 0);
    // three-cycle miss, ack, then a hit
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step(C_FRZ, 0, 3, 1, 0);
    step(C_FRZ, 1, 3, 1, 0);
    step(C_FRZ, 2, 3, 1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  step(C_RUN, 3, 3, 1, 0);
    step(C_RUN, 3, 3, 1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step(C_RUN, 3, 3, 1, 0);
    // miss with load-use and branch pending
    set_in(0, 1, 4, 0, 4, 0, 1, 1, 1, 0);  step(C_FRZ, 3, 3, 1, 0);
    step(C_FRZ, 4, 3, 1, 0);
    set_in(0, 1, 4, 0, 4, 0, 1, 1, 1, 1);  step(C_LU,  5, 3, 1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step(C_RUN, 5, 4, 1, 0);
    // unacked miss trips the watchdog after four MEMWAIT cycles
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step(C_FRZ, 5, 4, 1, 0);
    step(C_FRZ, 6, 4, 1, 0);
    step(C_FRZ, 7, 4, 1, 0);
    step(C_FRZ, 8, 4, 1, 0);
    step(C_FRZ, 9, 4, 1, 0);
    step(C_FRZ, 10, 4, 1, 1);
    step(C_FRZ, 11, 4, 1, 1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  step(C_RST, 12, 4, 1, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  step(C_RUN, 0, 0, 0, 0);
    step(C_RUN, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  step(C_RUN, 0, 0, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Resolves three hazard sources with fixed priority: data-cache miss (freeze), load-use (bubble) and taken branch in ID (flush).
- Drives the hold/flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps saturating performance counters and a miss-timeout watchdog.

Parameters:
- CNT_W, 32, width of each performance counter.
- TIMEOUT, 1024, maximum MEMWAIT cycles before err_o is set; must be ≥ 2.

Ports:
- clk_i  in  1  pipeline clock
- rst_i  in  1  reset; synchronous, active-high
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_RDaddr_i  in  5  destination register of the instruction in EX
- IFID_RS1addr_i  in  5  rs1 of the instruction in ID
- IFID_RS2addr_i  in  5  rs2 of the instruction in ID
- IFID_UsesRS1_i  in  1  instruction in ID reads rs1
- IFID_UsesRS2_i  in  1  instruction in ID reads rs2
- BranchTaken_i  in  1  branch or jump resolved as taken in ID
- DcacheReq_i  in  1  instruction in MEM accesses the data cache (MemRead|MemWrite)
- DcacheAck_i  in  1  data cache access completes this cycle
- PCWrite_o  out  1  PC may update
- IFIDStall_o  out  1  IF/ID holds its contents
- IFIDFlush_o  out  1  IF/ID loads a NOP
- IDEXStall_o  out  1  ID/EX holds its contents
- IDEXBubble_o  out  1  ID/EX loads all-zero control bits
- EXMEMStall_o  out  1  EX/MEM holds its contents
- MEMWBStall_o  out  1  MEM/WB holds its contents
- stall_cnt_o  out  CNT_W  cycles spent frozen by cache misses
- bubble_cnt_o  out  CNT_W  load-use bubbles inserted
- flush_cnt_o  out  CNT_W  IF/ID flushes performed
- err_o  out  1  sticky flag: a miss exceeded TIMEOUT cycles

Behaviour:
- FSM states: RUN, MEMWAIT. The state, a wait counter (width clog2(TIMEOUT+1)), the three perf counters and err_o are registered. Control outputs are combinational from the state and the inputs.
- Reset (rst_i=1, sampled at the clock edge):
  - Next state is RUN; all counters and err_o clear to 0.
  - While rst_i is high: PCWrite_o=0, IFIDFlush_o=1, IDEXBubble_o=1, all *Stall_o=0.
  - Reset asserted during MEMWAIT aborts the wait without setting err_o.
- Definitions:
  - miss = DcacheReq_i & ~DcacheAck_i
  - lu = IDEX_MemRead_i & (IDEX_RDaddr_i≠0) & ((IFID_UsesRS1_i & RS1 match) | (IFID_UsesRS2_i & RS2 match)), where a match is IDEX_RDaddr_i equal to that source address.
- Default (no hazard): PCWrite_o=1; all other controls 0.
- Priority 1, freeze: condition is (RUN & miss) or MEMWAIT & ~DcacheAck_i.
  - PCWrite_o=0; IFIDStall_o, IDEXStall_o, EXMEMStall_o and MEMWBStall_o all =1.
  - Flush and bubble are forced to 0.
  - RUN→MEMWAIT on RUN & miss.
  - A hit (DcacheReq_i & DcacheAck_i in RUN) causes no stall.
- MEMWAIT exit: when DcacheAck_i=1, no freeze that cycle; the pipeline advances and the next state is RUN. In that same cycle, priorities 2 and 3 are evaluated normally.
- Priority 2, load-use (lu and no freeze):
  - PCWrite_o=0, IFIDStall_o=1, IDEXBubble_o=1.
  - IFIDFlush_o is suppressed; the branch is re-evaluated next cycle with forwarded operands.
  - Exactly one bubble results, because the bubble clears IDEX_MemRead_i on the following cycle.
- Priority 3, flush (BranchTaken_i, no freeze, no lu): IFIDFlush_o=1, PCWrite_o=1.
- Counters (all saturate at all-ones, no wrap):
  - stall_cnt_o increments on every freeze cycle.
  - bubble_cnt_o increments on every cycle with IDEXBubble_o=1 outside reset.
  - flush_cnt_o increments on every cycle with IFIDFlush_o=1 outside reset.
- Watchdog:
  - The wait counter clears on entry to MEMWAIT and increments each MEMWAIT cycle.
  - Reaching TIMEOUT sets err_o, which stays set until reset.
  - The pipeline remains frozen; there is no forced exit.
- Simultaneous events: a miss together with lu and a branch freezes the whole pipeline only; lu and branch are held pending, because the inputs are frozen, and resolve after the ack.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - the state enum (RUN, MEMWAIT)
  - the REG_ZERO constant (5'd0)
  - the default CNT_W and TIMEOUT values
- One sub-module, hazard_detect: purely combinational, producing lu from the IDEX/IFID address inputs. It is reused by the forwarding checker.

Test Plan:
1. Reset released with all inputs 0 → PCWrite_o=1, every other control 0, all counters 0.
2. Load-use: IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RS1addr_i=5, IFID_UsesRS1_i=1 for one cycle, then MemRead=0 → exactly one cycle of PCWrite_o=0, IFIDStall_o=1, IDEXBubble_o=1; bubble_cnt_o=1. Repeat with RDaddr=0 → no bubble.
3. Taken branch: BranchTaken_i=1 for one cycle → IFIDFlush_o=1 for one cycle, PCWrite_o=1, flush_cnt_o=1. Same cycle with lu active → bubble only, flush_cnt_o unchanged.
4. Miss: DcacheReq_i=1, DcacheAck_i=0 for 3 cycles, then ack=1 → all four stalls =1 for 3 cycles, released in the ack cycle; stall_cnt_o=3; state back to RUN. Hit (req=1 and ack=1 in the same cycle) → no stall.
5. Miss concurrent with lu and BranchTaken_i → freeze only while waiting; after the ack, the bubble is applied and the flush is suppressed.
6. TIMEOUT=4, miss never acked → err_o=1 after the 4th MEMWAIT cycle and stays frozen; rst_i pulse → err_o=0, state RUN, counters 0.
